di_ch: RTL and testbench

//  Digital-input channel: the receive-side counterpart of the DO channel.
//  - Synchronises and debounces one field input.
//  - Periodically drives a line-test pulse and checks that the input follows it
//    (stuck-high / short diagnosis).
//  - Substitutes a configured safe value while the station fault is active.
//  - Uses the same byte-wide parameter-write / status-read bus as the other

---
 rtl/ch_pkg.sv | 38 +++
 rtl/di_debounce.sv | 56 +++++
 rtl/di_ch.sv | 248 ++++++++++++++++++++++++
 tb/tb_di_ch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ch_pkg.sv
// ch_pkg: codes and helpers shared by the channel blocks (di_ch, do_ch).
package ch_pkg;

    // Safe-value selection codes, shared with the output channel.
    localparam logic [7:0] DO_MIN  = 8'h00;
    localparam logic [7:0] DO_MAX  = 8'h01;
    localparam logic [7:0] DO_KEEP = 8'h02;
    localparam logic [7:0] DO_SET  = 8'h03;

    // LED control codes.
    localparam logic [1:0] LED_ON    = 2'b00;
    localparam logic [1:0] LED_OFF   = 2'b01;
    localparam logic [1:0] LED_BLINK = 2'b10;

    // Default status base and config register offsets from the channel base.
    localparam logic [11:0] STAT_ADD_DEF   = 12'd2112;
    localparam logic [11:0] OFS_CH_EN      = 12'd0;
    localparam logic [11:0] OFS_DIAG_EN    = 12'd1;
    localparam logic [11:0] OFS_FILTER     = 12'd2;
    localparam logic [11:0] OFS_DIAG_CYCLE = 12'd3;
    localparam logic [11:0] OFS_SAFE_TYPE  = 12'd5;
    localparam logic [11:0] OFS_SAFE_VALUE = 12'd6;
    localparam logic [11:0] OFS_TEST_DELAY = 12'd8;

    // Line-test sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_WAIT   = 2'd3
    } diag_state_e;

    // Scale an 8-bit configured count by a clock-count unit.
    function automatic logic [31:0] scale_ticks(input logic [7:0] n, input int unsigned unit);
        return {24'd0, n} * unit;
    endfunction

endpackage

// File: rtl/di_debounce.sv
// di_debounce: two-flop synchroniser plus stable-time filter that can be frozen.
module di_debounce
    import ch_pkg::*;
#(
    parameter int unsigned CLK_100US = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       freeze,
    input  logic [7:0] filter,
    output logic       din_sync,
    output logic       di_filt
);

    logic [1:0]  sync_q, sync_d;
    logic [31:0] cnt_q, cnt_d;
    logic        filt_q, filt_d;
    logic [31:0] limit;

    assign limit = scale_ticks(filter, CLK_100US);

    // Accept a new level only after it has differed from the filtered value for 'limit' clocks.
    always_comb begin
        sync_d = {sync_q[0], din};
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (!freeze) begin
            if (sync_q[1] == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q + 32'd1 >= limit) begin
                filt_d = sync_q[1];
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // Synchroniser and filter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign din_sync = sync_q[1];
    assign di_filt  = filt_q;

endmodule

// File: rtl/di_ch.sv
// di_ch: digital-input channel with debounce, line-test diagnosis and fault substitution.
module di_ch
    import ch_pkg::*;
#(
    parameter logic [11:0] CH_ADD    = 12'd0,
    parameter logic [11:0] STAT_ADD  = STAT_ADD_DEF,
    parameter int unsigned CLK_500US = 25000,
    parameter int unsigned CLK_100US = 5000,
    parameter int unsigned CNT_STUCK = 5,
    parameter int unsigned FAIL_N    = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_din,
    input  logic        fault,
    input  logic [11:0] im_paraddr,
    input  logic        i_parwren,
    input  logic [7:0]  im_pardata,
    input  logic [11:0] im_rdaddr,
    input  logic        i_rden,
    output logic [7:0]  om_rddata,
    output logic        o_test_pulse,
    output logic [1:0]  led_ctrl
);

    localparam logic [11:0] A_CH_EN      = CH_ADD + OFS_CH_EN;
    localparam logic [11:0] A_DIAG_EN    = CH_ADD + OFS_DIAG_EN;
    localparam logic [11:0] A_FILTER     = CH_ADD + OFS_FILTER;
    localparam logic [11:0] A_DIAG_CYCLE = CH_ADD + OFS_DIAG_CYCLE;
    localparam logic [11:0] A_SAFE_TYPE  = CH_ADD + OFS_SAFE_TYPE;
    localparam logic [11:0] A_SAFE_VALUE = CH_ADD + OFS_SAFE_VALUE;
    localparam logic [11:0] A_TEST_DELAY = CH_ADD + OFS_TEST_DELAY;
    localparam logic [11:0] A_STAT_VAL   = STAT_ADD;
    localparam logic [11:0] A_STAT_DIAG  = STAT_ADD + 12'd1;
    localparam int          HI_W         = $clog2(CNT_STUCK + 1);
    localparam logic [HI_W-1:0] HI_MAX   = HI_W'(CNT_STUCK);

    logic [7:0]        ch_en_q, ch_en_d, diag_en_q, diag_en_d, filter_q, filter_d;
    logic [7:0]        diag_cycle_q, diag_cycle_d, safe_type_q, safe_type_d;
    logic [7:0]        safe_value_q, safe_value_d, test_delay_q, test_delay_d;
    logic [7:0]        om_rddata_q, om_rddata_d, rd_data;
    logic [1:0]        fault_sync_q, fault_sync_d;
    logic              keep_val_q, keep_val_d, di_val_q, di_val_d;
    diag_state_e       state_q, state_d;
    logic [31:0]       timer_q, timer_d, cyc_cnt_q, cyc_cnt_d;
    logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic              fail_q, fail_d, pulse_q, pulse_d, diag_res_q, diag_res_d;
    logic [FAIL_N-1:0] fail_sh_q, fail_sh_d;
    logic              din_sync, di_filt, debounce_freeze, diag_active;
    logic [31:0]       settle_ticks, window_ticks, cyc_ticks;

    assign debounce_freeze = (state_q != ST_IDLE);
    assign diag_active     = (ch_en_q == 8'h01) && (diag_en_q == 8'h01);
    assign settle_ticks    = scale_ticks({4'd0, test_delay_q[3:0]}, CLK_500US);
    assign window_ticks    = scale_ticks({4'd0, test_delay_q[7:4]}, CLK_500US);
    assign cyc_ticks       = scale_ticks(diag_cycle_q, 200 * CLK_500US);

    di_debounce #(.CLK_100US(CLK_100US)) u_debounce (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .din      (i_din),
        .freeze   (debounce_freeze),
        .filter   (filter_q),
        .din_sync (din_sync),
        .di_filt  (di_filt)
    );

    // Configuration register writes; unknown addresses are ignored.
    always_comb begin
        ch_en_d      = ch_en_q;
        diag_en_d    = diag_en_q;
        filter_d     = filter_q;
        diag_cycle_d = diag_cycle_q;
        safe_type_d  = safe_type_q;
        safe_value_d = safe_value_q;
        test_delay_d = test_delay_q;
        if (i_parwren) begin
            case (im_paraddr)
                A_CH_EN:      ch_en_d      = im_pardata;
                A_DIAG_EN:    diag_en_d    = im_pardata;
                A_FILTER:     filter_d     = im_pardata;
                A_DIAG_CYCLE: diag_cycle_d = im_pardata;
                A_SAFE_TYPE:  safe_type_d  = im_pardata;
                A_SAFE_VALUE: safe_value_d = im_pardata;
                A_TEST_DELAY: test_delay_d = im_pardata;
                default:      ;
            endcase
        end
    end

    // Read mux; the registered read data holds while no read is strobed.
    always_comb begin
        rd_data = 8'h00;
        case (im_rdaddr)
            A_CH_EN:      rd_data = ch_en_q;
            A_DIAG_EN:    rd_data = diag_en_q;
            A_FILTER:     rd_data = filter_q;
            A_DIAG_CYCLE: rd_data = diag_cycle_q;
            A_SAFE_TYPE:  rd_data = safe_type_q;
            A_SAFE_VALUE: rd_data = safe_value_q;
            A_TEST_DELAY: rd_data = test_delay_q;
            A_STAT_VAL:   rd_data = {7'd0, di_val_q};
            A_STAT_DIAG:  rd_data = {7'd0, diag_res_q};
            default:      rd_data = 8'h00;
        endcase
        om_rddata_d = i_rden ? rd_data : om_rddata_q;
    end

    // Fault path: remember the filtered input on fault onset, substitute the safe value while active.
    always_comb begin
        fault_sync_d = {fault_sync_q[0], fault};
        keep_val_d   = keep_val_q;
        di_val_d     = di_filt;
        if (fault_sync_q == 2'b01) begin
            keep_val_d = di_filt;
        end
        if (fault_sync_q[1]) begin
            case (safe_type_q)
                DO_MIN:  di_val_d = 1'b0;
                DO_MAX:  di_val_d = 1'b1;
                DO_KEEP: di_val_d = keep_val_q;
                DO_SET:  di_val_d = safe_value_q[0];
                default: di_val_d = di_val_q;
            endcase
        end
    end

    // Line-test sequencer; the timer counts test clocks including the current one, so the pulse lasts 'window' clocks.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cyc_cnt_d = cyc_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        fail_d    = fail_q;
        fail_sh_d = fail_sh_q;
        pulse_d   = pulse_q;
        if (!diag_active) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            cyc_cnt_d = '0;
            hi_cnt_d  = '0;
            fail_d    = 1'b0;
            fail_sh_d = '0;
            pulse_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (di_filt) begin
                        state_d  = ST_SETTLE;
                        pulse_d  = 1'b1;
                        timer_d  = 32'd1;
                        hi_cnt_d = '0;
                        fail_d   = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    timer_d = timer_q + 32'd1;
                    if (timer_q >= settle_ticks) begin
                        if (window_ticks <= settle_ticks) begin
                            state_d   = ST_WAIT;
                            pulse_d   = 1'b0;
                            cyc_cnt_d = '0;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    timer_d = timer_q + 32'd1;
                    if (din_sync) begin
                        if (hi_cnt_q != HI_MAX) begin
                            hi_cnt_d = hi_cnt_q + HI_W'(1);
                        end
                    end else begin
                        hi_cnt_d = '0;
                    end
                    fail_d = fail_q | (hi_cnt_d == HI_MAX);
                    if (timer_q >= window_ticks) begin
                        state_d   = ST_WAIT;
                        pulse_d   = 1'b0;
                        cyc_cnt_d = '0;
                        fail_sh_d = {fail_sh_q[FAIL_N-2:0], fail_d};
                    end
                end
                ST_WAIT: begin
                    cyc_cnt_d = cyc_cnt_q + 32'd1;
                    if (cyc_cnt_q >= cyc_ticks) begin
                        state_d   = ST_IDLE;
                        timer_d   = '0;
                        cyc_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        diag_res_d = (&fail_sh_q) && (diag_en_q == 8'h01);
    end

    // State registers for configuration, fault path, sequencer and read port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch_en_q      <= '0;
            diag_en_q    <= '0;
            filter_q     <= '0;
            diag_cycle_q <= '0;
            safe_type_q  <= '0;
            safe_value_q <= '0;
            test_delay_q <= '0;
            om_rddata_q  <= '0;
            fault_sync_q <= '0;
            keep_val_q   <= 1'b0;
            di_val_q     <= 1'b0;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            cyc_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            fail_q       <= 1'b0;
            fail_sh_q    <= '0;
            pulse_q      <= 1'b0;
            diag_res_q   <= 1'b0;
        end else begin
            ch_en_q      <= ch_en_d;
            diag_en_q    <= diag_en_d;
            filter_q     <= filter_d;
            diag_cycle_q <= diag_cycle_d;
            safe_type_q  <= safe_type_d;
            safe_value_q <= safe_value_d;
            test_delay_q <= test_delay_d;
            om_rddata_q  <= om_rddata_d;
            fault_sync_q <= fault_sync_d;
            keep_val_q   <= keep_val_d;
            di_val_q     <= di_val_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            cyc_cnt_q    <= cyc_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            fail_q       <= fail_d;
            fail_sh_q    <= fail_sh_d;
            pulse_q      <= pulse_d;
            diag_res_q   <= diag_res_d;
        end
    end

    assign om_rddata    = om_rddata_q;
    assign o_test_pulse = pulse_q;
    assign led_ctrl     = (ch_en_q != 8'h01) ? LED_OFF : (diag_res_q ? LED_BLINK : LED_ON);

endmodule

// File: tb/tb_di_ch.sv
// tb_di_ch: directed bench for di_ch with shortened time units (500us = 25 clocks, 100us = 5 clocks).
module tb_di_ch;
    import ch_pkg::*;

    localparam logic [11:0] R_CH_EN      = 12'h000;
    localparam logic [11:0] R_DIAG_EN    = 12'h001;
    localparam logic [11:0] R_FILTER     = 12'h002;
    localparam logic [11:0] R_DIAG_CYCLE = 12'h003;
    localparam logic [11:0] R_SAFE_TYPE  = 12'h005;
    localparam logic [11:0] R_SAFE_VALUE = 12'h006;
    localparam logic [11:0] R_TEST_DELAY = 12'h008;
    localparam logic [11:0] R_STAT_VAL   = 12'd2112;
    localparam logic [11:0] R_STAT_DIAG  = 12'd2113;
    localparam int          LIMIT        = 1000;

    logic        clk, rst_n, din, fault_in, parwren, rden;
    logic [11:0] paraddr, rdaddr;
    logic [7:0]  pardata, rddata, rd;
    logic        test_pulse;
    logic [1:0]  led;
    logic        follow;
    int          errors, checks, gap, width;

    di_ch #(
        .CH_ADD    (12'd0),
        .STAT_ADD  (12'd2112),
        .CLK_500US (25),
        .CLK_100US (5),
        .CNT_STUCK (5),
        .FAIL_N    (5)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_din        (din),
        .fault        (fault_in),
        .im_paraddr   (paraddr),
        .i_parwren    (parwren),
        .im_pardata   (pardata),
        .im_rdaddr    (rdaddr),
        .i_rden       (rden),
        .om_rddata    (rddata),
        .o_test_pulse (test_pulse),
        .led_ctrl     (led)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge; in follow mode the input mirrors ~pulse.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (follow) din = ~test_pulse;
        end
    endtask

    task automatic writeReg(input logic [11:0] a, input logic [7:0] d);
        paraddr = a;
        pardata = d;
        parwren = 1'b1;
        applyStimulus(1);
        parwren = 1'b0;
    endtask

    task automatic readReg(input logic [11:0] a, output logic [7:0] d);
        rdaddr = a;
        rden   = 1'b1;
        applyStimulus(1);
        rden   = 1'b0;
        d      = rddata;
    endtask

    task automatic waitPulse(input logic level, input string tag, output int waited);
        waited = 0;
        while (test_pulse !== level && waited < LIMIT) begin
            applyStimulus(1);
            waited++;
        end
        if (waited >= LIMIT) checkOutput({tag, "_timeout"}, 32'(test_pulse), 32'(level));
    endtask

    task automatic pulseWidth(input string tag, output int g, output int w);
        waitPulse(1'b1, tag, g);
        w = 0;
        while (test_pulse === 1'b1 && w < LIMIT) begin
            w++;
            applyStimulus(1);
        end
        if (w >= LIMIT) checkOutput({tag, "_stuck_high"}, 32'(test_pulse), 32'd0);
    endtask

    initial begin
        errors = 0; checks = 0; follow = 1'b0;
        rst_n = 1'b0; din = 1'b0; fault_in = 1'b0;
        parwren = 1'b0; rden = 1'b0; paraddr = '0; pardata = '0; rdaddr = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rddata", 32'(rddata), 32'h00);
        checkOutput("rst_pulse", 32'(test_pulse), 32'd0);
        checkOutput("rst_led", 32'(led), 32'b01);
        checkOutput("rst_dival", 32'(dut.di_val_q), 32'd0);
        rst_n = 1'b1;
        applyStimulus(2);

        // 1: debounce with filter=10 -> 50 clocks stable, plus 2 sync and 1 output stage
        $display("[TB] debounce");
        writeReg(R_CH_EN, 8'h01);
        writeReg(R_FILTER, 8'd10);
        readReg(R_FILTER, rd);
        checkOutput("rd_filter", 32'(rd), 32'd10);
        din = 1'b1;
        applyStimulus(52);
        checkOutput("dival_52", 32'(dut.di_val_q), 32'd0);
        applyStimulus(1);
        checkOutput("dival_53", 32'(dut.di_val_q), 32'd1);
        readReg(R_STAT_VAL, rd);
        checkOutput("rd_stat_val", 32'(rd), 32'h01);
        din = 1'b0;
        applyStimulus(40);
        din = 1'b1;
        checkOutput("glitch_filt", 32'(dut.di_filt), 32'd1);
        applyStimulus(60);
        readReg(R_STAT_VAL, rd);
        checkOutput("glitch_val", 32'(rd), 32'h01);

        // 2: healthy line, test_delay=0x42 -> settle 50, window 100
        $display("[TB] healthy line test");
        writeReg(R_TEST_DELAY, 8'h42);
        writeReg(R_DIAG_CYCLE, 8'h00);
        follow = 1'b1;
        din = 1'b1;
        writeReg(R_DIAG_EN, 8'h01);
        pulseWidth("ok1", gap, width);
        checkOutput("ok1_width", 32'(width), 32'd100);
        pulseWidth("ok2", gap, width);
        checkOutput("ok2_gap", 32'(gap), 32'd2);
        checkOutput("ok2_width", 32'(width), 32'd100);
        checkOutput("ok_failsh", 32'(dut.fail_sh_q), 32'h00);
        checkOutput("ok_diagres", 32'(dut.diag_res_q), 32'd0);
        checkOutput("ok_led", 32'(led), 32'b00);

        // 3: stuck-high input -> diag result after the 5th failed test
        $display("[TB] stuck input");
        follow = 1'b0;
        din = 1'b1;
        for (int i = 0; i < 4; i++) pulseWidth("stuck", gap, width);
        checkOutput("stuck4_failsh", 32'(dut.fail_sh_q), 32'h0F);
        checkOutput("stuck4_diagres", 32'(dut.diag_res_q), 32'd0);
        pulseWidth("stuck5", gap, width);
        // 6: shortened window -> skipped tests keep fail_sh unchanged
        writeReg(R_TEST_DELAY, 8'h22);
        checkOutput("stuck5_diagres", 32'(dut.diag_res_q), 32'd1);
        checkOutput("stuck5_led", 32'(led), 32'b10);
        follow = 1'b1;
        readReg(R_STAT_DIAG, rd);
        checkOutput("rd_stat_diag", 32'(rd), 32'h01);
        $display("[TB] skipped tests");
        pulseWidth("skip1", gap, width);
        pulseWidth("skip2", gap, width);
        checkOutput("skip2_width", 32'(width), 32'd50);
        pulseWidth("skip3", gap, width);
        checkOutput("skip3_width", 32'(width), 32'd50);
        checkOutput("skip_failsh", 32'(dut.fail_sh_q), 32'h1F);
        checkOutput("skip_diagres", 32'(dut.diag_res_q), 32'd1);
        writeReg(R_TEST_DELAY, 8'h42);
        pulseWidth("recover", gap, width);
        checkOutput("recover_width", 32'(width), 32'd100);
        applyStimulus(1);
        checkOutput("recover_diagres", 32'(dut.diag_res_q), 32'd0);
        checkOutput("recover_led", 32'(led), 32'b00);
        readReg(12'hFFF, rd);
        checkOutput("rd_unmapped", 32'(rd), 32'h00);

        // 4: fault substitution
        $display("[TB] fault substitution");
        writeReg(R_DIAG_EN, 8'h00);
        follow = 1'b0;
        din = 1'b1;
        applyStimulus(60);
        writeReg(R_SAFE_TYPE, 8'h02);
        fault_in = 1'b1;
        applyStimulus(4);
        din = 1'b0;
        applyStimulus(60);
        checkOutput("fault_filt", 32'(dut.di_filt), 32'd0);
        readReg(R_STAT_VAL, rd);
        checkOutput("fault_keep", 32'(rd), 32'h01);
        writeReg(R_SAFE_VALUE, 8'h00);
        writeReg(R_SAFE_TYPE, 8'h03);
        applyStimulus(2);
        readReg(R_STAT_VAL, rd);
        checkOutput("fault_set0", 32'(rd), 32'h00);
        writeReg(R_SAFE_TYPE, 8'h01);
        applyStimulus(2);
        readReg(R_STAT_VAL, rd);
        checkOutput("fault_max", 32'(rd), 32'h01);
        fault_in = 1'b0;
        applyStimulus(4);
        readReg(R_STAT_VAL, rd);
        checkOutput("fault_release", 32'(rd), 32'h00);

        // 5: channel disabled in the middle of CHECK
        $display("[TB] disable mid-test");
        din = 1'b1;
        applyStimulus(60);
        follow = 1'b1;
        writeReg(R_DIAG_EN, 8'h01);
        waitPulse(1'b1, "abort_rise", gap);
        applyStimulus(60);
        checkOutput("abort_in_check", 32'(dut.state_q), 32'(ST_CHECK));
        writeReg(R_CH_EN, 8'h00);
        applyStimulus(1);
        checkOutput("abort_pulse", 32'(test_pulse), 32'd0);
        checkOutput("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        checkOutput("abort_led", 32'(led), 32'b01);
        checkOutput("abort_timer", dut.timer_q, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
